// File: rtl/ro_puf_pkg.sv
// -----------------------------------------------------------------------------
// ro_puf_pkg
// Shared types and constants for the sequential ring-oscillator PUF evaluator.
//   state_e      : evaluator FSM states
//   MODE_RACE    : first counter to reach the target decides the bit
//   MODE_WINDOW  : counts over a fixed window are compared
//   race_outcome : maps the two "target reached" flags to {bit, tie}
// -----------------------------------------------------------------------------
package ro_puf_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      MEASURE = 3'd2,
      COMPARE = 3'd3,
      DONE    = 3'd4
   } state_e;

   localparam logic MODE_RACE   = 1'b0;
   localparam logic MODE_WINDOW = 1'b1;

   // Returns {response_bit, tie_flag} for a race. Neither flag set means the
   // measurement ended on the timeout.
   function automatic logic [1:0] race_outcome(input logic reach_a, input logic reach_b);
      logic [1:0] res;
      case ({reach_a, reach_b})
         2'b11:   res = 2'b11;
         2'b10:   res = 2'b10;
         2'b01:   res = 2'b00;
         2'b00:   res = 2'b01;
         default: res = 2'b01;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ro_puf_seq_eval_edge_counter.sv
// -----------------------------------------------------------------------------
// ro_edge_counter
// Brings one asynchronous ring-oscillator output into the clk domain through a
// two-flop synchroniser, detects rising edges and counts them in a saturating
// counter.
//   clk, reset : system clock, asynchronous active-high reset
//   ro_in      : asynchronous RO output (already selected by the caller)
//   clear      : synchronous clear of the counter (synchroniser keeps running)
//   count_en   : detected edges are counted only while this is high
//   count      : current edge count, saturates at all-ones
// -----------------------------------------------------------------------------
module ro_edge_counter
   import ro_puf_pkg::*;
#(
   parameter int CNT_W = 22
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ro_in,
   input  logic             clear,
   input  logic             count_en,
   output logic [CNT_W-1:0] count
);

   // sync_q[0] may go metastable, sync_q[1] is the synchronised level,
   // sync_q[2] is the previous synchronised level used for edge detection.
   logic [2:0]       sync_q;
   logic [2:0]       sync_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             rise_s;

   // Synchroniser shift and rising-edge detect
   always_comb begin
      sync_d = {sync_q[1:0], ro_in};
      rise_s = sync_q[1] & ~sync_q[2];
   end

   // Saturating edge counter next state
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (count_en && rise_s && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Synchroniser and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= 3'b000;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/ro_puf_seq_eval.sv
// -----------------------------------------------------------------------------
// ro_puf_seq_eval
// Sequential ring-oscillator PUF evaluator. One pair of edge counters is
// time-multiplexed over RESP_BITS response bits. For bit i the RO selected in
// each bank is (challenge base + i) mod N_RO. Each bit goes through
// SETTLE -> MEASURE -> COMPARE; after the last bit a one-cycle DONE state
// drops busy/ro_en and pulses done.
//   clk, reset  : system clock, asynchronous active-high reset
//   start       : begin an evaluation (accepted in IDLE only)
//   mode        : 0 = race, 1 = window (latched at start)
//   challenge   : [SEL_W-1:0] bank A base, [2*SEL_W-1:SEL_W] bank B base
//   target      : race terminal count (latched)
//   window_len  : window length, or race timeout (latched)
//   ro_a, ro_b  : asynchronous RO bank outputs
//   ro_en       : RO bank enable
//   busy, done  : handshake; done is a one-cycle pulse
//   response    : response bits, held until the next accepted start
//   tie_mask    : per-bit tie / timeout flags
// -----------------------------------------------------------------------------
module ro_puf_seq_eval
   import ro_puf_pkg::*;
#(
   parameter int N_RO       = 16,
   parameter int SEL_W      = 4,
   parameter int RESP_BITS  = 8,
   parameter int CNT_W      = 22,
   parameter int WIN_W      = 24,
   parameter int SETTLE_CYC = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 mode,
   input  logic [2*SEL_W-1:0]   challenge,
   input  logic [CNT_W-1:0]     target,
   input  logic [WIN_W-1:0]     window_len,
   input  logic [N_RO-1:0]      ro_a,
   input  logic [N_RO-1:0]      ro_b,
   output logic                 ro_en,
   output logic                 busy,
   output logic                 done,
   output logic [RESP_BITS-1:0] response,
   output logic [RESP_BITS-1:0] tie_mask
);

   localparam int BIT_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   state_e               state_q,    state_d;
   logic                 mode_q,     mode_d;
   logic [SEL_W-1:0]     chal_a_q,   chal_a_d;
   logic [SEL_W-1:0]     chal_b_q,   chal_b_d;
   logic [CNT_W-1:0]     target_q,   target_d;
   logic [WIN_W-1:0]     win_len_q,  win_len_d;
   logic [BIT_W-1:0]     bit_q,      bit_d;
   logic [SET_W-1:0]     settle_q,   settle_d;
   logic [WIN_W-1:0]     win_q,      win_d;
   logic                 busy_q,     busy_d;
   logic                 done_q,     done_d;
   logic                 ro_en_q,    ro_en_d;
   logic [RESP_BITS-1:0] response_q, response_d;
   logic [RESP_BITS-1:0] tie_q,      tie_d;

   logic [SEL_W-1:0]     sel_a_s;
   logic [SEL_W-1:0]     sel_b_s;
   logic                 ro_a_sel_s;
   logic                 ro_b_sel_s;
   logic [CNT_W-1:0]     cnt_a_s;
   logic [CNT_W-1:0]     cnt_b_s;
   logic                 reach_a_s;
   logic                 reach_b_s;
   logic                 timeout_s;
   logic                 win_last_s;
   logic                 measure_exit_s;
   logic                 count_en_s;
   logic                 clear_s;
   logic                 settle_last_s;
   logic                 cmp_bit_s;
   logic                 cmp_tie_s;

   // RO selection: SEL_W-bit addition gives the mod-N_RO wrap for free
   always_comb begin
      sel_a_s    = chal_a_q + SEL_W'(bit_q);
      sel_b_s    = chal_b_q + SEL_W'(bit_q);
      ro_a_sel_s = ro_a[sel_a_s];
      ro_b_sel_s = ro_b[sel_b_s];
   end

   // Measurement-phase status and counter control
   always_comb begin
      reach_a_s     = (cnt_a_s >= target_q);
      reach_b_s     = (cnt_b_s >= target_q);
      timeout_s     = (win_q == win_len_q);
      win_last_s    = ((win_q + WIN_W'(1)) == win_len_q);
      settle_last_s = (settle_q == SET_W'(SETTLE_CYC - 1));
      if (mode_q == MODE_WINDOW) begin
         measure_exit_s = win_last_s;
      end else begin
         measure_exit_s = reach_a_s | reach_b_s | timeout_s;
      end
      // In race mode counting stops in the exit cycle so a late edge on the
      // losing bank cannot turn a clean win into a false tie. In window mode
      // the exit cycle is the last counting cycle of the window.
      if (state_q == MEASURE) begin
         count_en_s = (mode_q == MODE_WINDOW) | ~measure_exit_s;
      end else begin
         count_en_s = 1'b0;
      end
      clear_s = (state_q == IDLE) || (state_q == SETTLE);
   end

   // Bit decision evaluated on the frozen counts during COMPARE
   always_comb begin
      cmp_bit_s = 1'b0;
      cmp_tie_s = 1'b0;
      if (mode_q == MODE_WINDOW) begin
         cmp_bit_s = (cnt_a_s > cnt_b_s);
         cmp_tie_s = (cnt_a_s == cnt_b_s);
      end else begin
         {cmp_bit_s, cmp_tie_s} = race_outcome(reach_a_s, reach_b_s);
      end
   end

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk      (clk),
      .reset    (reset),
      .ro_in    (ro_a_sel_s),
      .clear    (clear_s),
      .count_en (count_en_s),
      .count    (cnt_a_s)
   );

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk      (clk),
      .reset    (reset),
      .ro_in    (ro_b_sel_s),
      .clear    (clear_s),
      .count_en (count_en_s),
      .count    (cnt_b_s)
   );

   // FSM next state and registered-output next values
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      chal_a_d   = chal_a_q;
      chal_b_d   = chal_b_q;
      target_d   = target_q;
      win_len_d  = win_len_q;
      bit_d      = bit_q;
      settle_d   = settle_q;
      win_d      = win_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ro_en_d    = ro_en_q;
      response_d = response_q;
      tie_d      = tie_q;

      case (state_q)
         IDLE: begin
            settle_d = '0;
            win_d    = '0;
            if (start) begin
               mode_d     = mode;
               chal_a_d   = challenge[SEL_W-1:0];
               chal_b_d   = challenge[2*SEL_W-1:SEL_W];
               target_d   = target;
               win_len_d  = window_len;
               bit_d      = '0;
               busy_d     = 1'b1;
               ro_en_d    = 1'b1;
               response_d = '0;
               tie_d      = '0;
               state_d    = SETTLE;
            end else begin
               state_d = IDLE;
            end
         end

         SETTLE: begin
            win_d = '0;
            if (settle_last_s) begin
               settle_d = '0;
               // A zero-length window has no counting cycles at all
               if ((mode_q == MODE_WINDOW) && (win_len_q == '0)) begin
                  state_d = COMPARE;
               end else begin
                  state_d = MEASURE;
               end
            end else begin
               settle_d = settle_q + SET_W'(1);
               state_d  = SETTLE;
            end
         end

         MEASURE: begin
            if (measure_exit_s) begin
               state_d = COMPARE;
            end else begin
               win_d   = win_q + WIN_W'(1);
               state_d = MEASURE;
            end
         end

         COMPARE: begin
            response_d[bit_q] = cmp_bit_s;
            tie_d[bit_q]      = cmp_tie_s;
            win_d             = '0;
            settle_d          = '0;
            if (bit_q == BIT_W'(RESP_BITS - 1)) begin
               state_d = DONE;
            end else begin
               bit_d   = bit_q + BIT_W'(1);
               state_d = SETTLE;
            end
         end

         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ro_en_d = 1'b0;
            state_d = IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            ro_en_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         mode_q     <= MODE_RACE;
         chal_a_q   <= '0;
         chal_b_q   <= '0;
         target_q   <= '0;
         win_len_q  <= '0;
         bit_q      <= '0;
         settle_q   <= '0;
         win_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ro_en_q    <= 1'b0;
         response_q <= '0;
         tie_q      <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         chal_a_q   <= chal_a_d;
         chal_b_q   <= chal_b_d;
         target_q   <= target_d;
         win_len_q  <= win_len_d;
         bit_q      <= bit_d;
         settle_q   <= settle_d;
         win_q      <= win_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ro_en_q    <= ro_en_d;
         response_q <= response_d;
         tie_q      <= tie_d;
      end
   end

   assign ro_en    = ro_en_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign response = response_q;
   assign tie_mask = tie_q;

endmodule
